ex_divider: RTL and testbench

Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions, located in the EX stage. It is fed from the ID/EX pipeline register. Its `busy_o` drives the pipeline control unit's `ex_div_i`, which stalls IF, IF/ID and ID/EX and flushes EX/MEM while a division is in flight. The result is presented for exactly one cycle (DONE), when `busy_o` drops and EX/MEM captures it.

---
 rtl/ex_divider_if.sv | 25 ++
 rtl/ex_divider.sv | 155 +++++++++++++++
 tb/tb_ex_divider.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_divider_if.sv
// Request/response bundle between the ID/EX stage and the EX-stage divider.
// The pipeline side drives the instruction fields. The divider returns its
// stall request and the one-cycle result.
interface ex_divider_if #(
  parameter int XLEN = 64
);
  logic            div_valid_i;
  logic [1:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output div_valid_i, op_i, word_i, src1_i, src2_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  div_valid_i, op_i, word_i, src1_i, src2_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_divider.sv
// ex_divider: iterative radix-2 restoring divider for the RV64M divide and
// remainder instructions, including the W forms.
//
// Operands are latched in IDLE as magnitudes. BUSY produces one quotient bit
// per cycle. DONE applies the sign fix and the special-case overrides, and
// presents the result for a single cycle.
//
// Optional build macro DIV_FAST_SPECIAL_EN: when it is defined, divide-by-zero
// and signed overflow skip the iterations and go from IDLE straight to DONE.
// Results are the same with or without the macro.
module ex_divider #(
  parameter int XLEN = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  ex_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  state_t          state, state_nxt;
  logic            busy, done;

  logic            is_signed, a_neg, b_neg, b_zero, sgn_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, dvnd_q;
  logic [6:0]      cnt_q;
  logic            q_neg_q, r_neg_q, sel_rem_q, word_q, zero_q, ovf_q;

  logic            ge;
  logic [XLEN-1:0] rem_sh, diff;
  logic [XLEN-1:0] quo_fix, rem_fix, sel;

  // Extend the incoming operands, take magnitudes, and flag the special cases
  always_comb begin
    is_signed = ~bus.op_i[0];
    if (bus.word_i) begin
      a_ext = is_signed ? {{(XLEN-32){bus.src1_i[31]}}, bus.src1_i[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.src1_i[31:0]};
      b_ext = is_signed ? {{(XLEN-32){bus.src2_i[31]}}, bus.src2_i[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.src2_i[31:0]};
    end else begin
      a_ext = bus.src1_i;
      b_ext = bus.src2_i;
    end
    a_neg   = is_signed & a_ext[XLEN-1];
    b_neg   = is_signed & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    b_zero  = (b_ext == '0);
    sgn_ovf = is_signed && (b_ext == '1) && (a_ext == (bus.word_i ? MIN_W : MIN_D));
  end

  // Compute one restoring step on the shifted {rem, quo} pair
  always_comb begin
    rem_sh = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    ge     = ({rem_q, quo_q[XLEN-1]} >= {1'b0, dvsr_q});
    diff   = rem_sh - dvsr_q;
  end

  // Hold the FSM state, and return to IDLE at once when reset is asserted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Compute the next state and the busy/done strobes
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = bus.div_valid_i;
        if (bus.div_valid_i) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_nxt = (b_zero | sgn_ovf) ? DONE : BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (!bus.div_valid_i)   state_nxt = IDLE;
        else if (cnt_q == 7'd1) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the operands in IDLE, then iterate in BUSY
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      word_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div_valid_i) begin
            rem_q     <= '0;
            quo_q     <= bus.word_i ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            dvsr_q    <= b_mag;
            dvnd_q    <= a_ext;
            cnt_q     <= bus.word_i ? 7'd32 : 7'd64;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            sel_rem_q <= bus.op_i[1];
            word_q    <= bus.word_i;
            zero_q    <= b_zero;
            ovf_q     <= sgn_ovf;
          end
        end
        BUSY: begin
          rem_q <= ge ? diff : rem_sh;
          quo_q <= {quo_q[XLEN-2:0], ge};
          cnt_q <= cnt_q - 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Apply the sign fix, the special overrides, and W sign extension in DONE
  always_comb begin
    quo_fix = q_neg_q ? -quo_q : quo_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
    sel     = sel_rem_q ? rem_fix : quo_fix;
    if (zero_q)     sel = sel_rem_q ? dvnd_q : '1;
    else if (ovf_q) sel = sel_rem_q ? '0 : dvnd_q;
    if (word_q)     sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
  end

  assign bus.busy_o   = reset_n & busy;
  assign bus.done_o   = done;
  assign bus.result_o = done ? sel : '0;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider. Expected results come from a behavioural
// division model. They are queued when an operation is issued and compared
// when done_o fires.
module tb_ex_divider;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  ex_divider_if #(.XLEN(64)) bus ();

  ex_divider #(.XLEN(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [63:0] result;
    int          latency;
    int          start;
    string       tag;
  } exp_t;

  exp_t sbQueue[$];
  exp_t monEntry;
  int   errorCount = 0;
  int   checkCount = 0;
  int   cycle      = 0;
  int   busyCount  = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  // Count clock cycles, so that latency is measured against the issue cycle
  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
    end
  endtask

  function automatic bit modelSpecial(input logic [1:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
    if (word)
      return (b[31:0] == 32'h0) ||
             (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) || (!op[0] && a == MIN64 && b == '1);
  endfunction

  function automatic logic [63:0] modelDiv(input logic [1:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = 32'h0;
    r   = 64'h0;
    if (word) begin
      if (b32 == 32'h0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : a32;
      else begin
        case (op)
          2'b00: r32 = $signed(a32) / $signed(b32);
          2'b01: r32 = a32 / b32;
          2'b10: r32 = $signed(a32) % $signed(b32);
          default: r32 = a32 % b32;
        endcase
      end
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'h0) r = op[1] ? a : '1;
      else if (!op[0] && a == MIN64 && b == '1) r = op[1] ? 64'h0 : a;
      else begin
        case (op)
          2'b00: r = $signed(a) / $signed(b);
          2'b01: r = a / b;
          2'b10: r = $signed(a) % $signed(b);
          default: r = a % b;
        endcase
      end
    end
    return r;
  endfunction

  function automatic int modelLatency(input logic [1:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
    bit fastBuild;
`ifdef DIV_FAST_SPECIAL_EN
    fastBuild = 1'b1;
`else
    fastBuild = 1'b0;
`endif
    if (fastBuild && modelSpecial(op, word, a, b)) return 2;
    return word ? 34 : 66;
  endfunction

  // Call just after a rising edge: drives a divide and queues its expected outcome
  task automatic applyStimulus(input logic [1:0] op, input logic word,
                               input logic [63:0] a, input logic [63:0] b, input string tag);
    exp_t e;
    bus.op_i        = op;
    bus.word_i      = word;
    bus.src1_i      = a;
    bus.src2_i      = b;
    bus.div_valid_i = 1'b1;
    e.result  = modelDiv(op, word, a, b);
    e.latency = modelLatency(op, word, a, b);
    e.start   = cycle;
    e.tag     = tag;
    sbQueue.push_back(e);
  endtask

  task automatic waitDone(input int maxCycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clock);
      seen = bus.done_o;
    end
    if (!seen) checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic runOp(input logic [1:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input string tag);
    applyStimulus(op, word, a, b, tag);
    waitDone(100, tag);
    @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // On each falling edge, score the completions and track busy-run length and the idle result
  always @(negedge clock) begin
    if (!reset_n) begin
      busyCount = 0;
    end else if (bus.done_o) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_done", 64'(bus.done_o), 64'd0);
      end else begin
        monEntry = sbQueue.pop_front();
        checkOutput({monEntry.tag, "_result"}, bus.result_o, monEntry.result);
        checkOutput({monEntry.tag, "_latency"}, 64'(cycle - monEntry.start + 1), 64'(monEntry.latency));
        checkOutput({monEntry.tag, "_busy_cycles"}, 64'(busyCount), 64'(monEntry.latency - 1));
      end
      checkOutput("busy_in_done", 64'(bus.busy_o), 64'd0);
      busyCount = 0;
    end else begin
      checkOutput("result_idle_zero", bus.result_o, 64'd0);
      if (bus.busy_o) busyCount++;
      else            busyCount = 0;
    end
  end

  // Guard against a hung run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    logic [1:0]  rop;
    logic        rword;
    logic [63:0] ra, rb;

    reset_n         = 1'b0;
    bus.div_valid_i = 1'b1;
    bus.op_i        = 2'b00;
    bus.word_i      = 1'b0;
    bus.src1_i      = 64'd9;
    bus.src2_i      = 64'd3;
    #12;
    checkOutput("reset_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset_done", 64'(bus.done_o), 64'd0);
    checkOutput("reset_result", bus.result_o, 64'd0);
    bus.div_valid_i = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    runOp(2'b01, 1'b0, 64'd100, 64'd7, "divu_100_7");
    runOp(2'b10, 1'b0, -64'sd7, 64'd2, "rem_m7_2");
    runOp(2'b00, 1'b0, -64'sd7, 64'd2, "div_m7_2");
    runOp(2'b00, 1'b0, 64'd5, 64'd0, "div_5_0");
    runOp(2'b11, 1'b0, 64'd5, 64'd0, "remu_5_0");
    runOp(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "divw_ovf");
    runOp(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "remw_ovf");
    runOp(2'b00, 1'b0, MIN64, '1, "div_ovf64");
    runOp(2'b10, 1'b0, MIN64, '1, "rem_ovf64");
    runOp(2'b11, 1'b1, 64'h1234_5678_0000_0007, 64'hFFFF_FFFF_0000_0000, "remuw_zero");

    // Back-to-back: the second divide is issued in the cycle after the first DONE
    applyStimulus(2'b01, 1'b0, 64'd10, 64'd3, "b2b_divu");
    waitDone(100, "b2b_divu");
    @(posedge clock);
    #1 applyStimulus(2'b11, 1'b0, 64'd10, 64'd3, "b2b_remu");
    waitDone(100, "b2b_remu");
    @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    @(posedge clock);
    #1;

    // Random mix of signed/unsigned, 64-bit/W, with small and large divisors
    for (int i = 0; i < 8; i++) begin
      rop   = 2'($urandom_range(0, 3));
      rword = 1'($urandom_range(0, 1));
      ra    = {$urandom, $urandom};
      rb    = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      runOp(rop, rword, ra, rb, $sformatf("rand%0d", i));
    end

    // Dropping div_valid_i mid-operation aborts without a done_o
    bus.op_i        = 2'b01;
    bus.word_i      = 1'b0;
    bus.src1_i      = 64'd1000;
    bus.src2_i      = 64'd9;
    bus.div_valid_i = 1'b1;
    repeat (10) @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_busy", 64'(bus.busy_o), 64'd0);
    repeat (80) @(posedge clock);
    #1;

    // Asynchronous reset mid-operation, then a fresh divide with valid held high
    applyStimulus(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 64'd12345, "rst_victim");
    repeat (20) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("midreset_done", 64'(bus.done_o), 64'd0);
    checkOutput("midreset_result", bus.result_o, 64'd0);
    sbQueue.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    applyStimulus(2'b00, 1'b0, -64'sd1000, 64'd7, "after_reset");
    waitDone(100, "after_reset");
    @(posedge clock);
    #1 bus.div_valid_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
